inner_prod_pipe: RTL

- Parametrised successor of the fixed 4-element inner-product DUT.
- Computes the unsigned inner product of an N_ELEMS-element input vector with a register-loaded coefficient vector.
- Fully pipelined, valid-only streaming: one beat per cycle, no backpressure.
- Adds two features the fixed DUT lacks: an optional per-beat running-accumulate mode, and a per-beat overflow flag.
- Sits behind the real-time signal interface. The coefficients come from the register block.

---
 rtl/inner_prod_pipe.sv | 132 +++++++++++++
 1 files changed

// File: rtl/inner_prod_pipe.sv
// Unsigned inner product of an input vector with a shadowed coefficient vector, optional running accumulate.
// Latency: 2 + clog2(N_ELEMS) cycles from the valid input edge to o_inner_prod_valid, fixed for all data and modes.
// No backpressure: a beat is accepted every cycle and every beat produces exactly one output.
module inner_prod_pipe #(
  parameter int N_ELEMS = 4,
  parameter int DATA_W  = 32
) (
  input  logic                             i_clk,
  input  logic                             i_sync_rst,
  input  logic [N_ELEMS-1:0][DATA_W-1:0]   i_coef_vec,
  input  logic                             i_coef_load,
  input  logic [N_ELEMS-1:0][DATA_W-1:0]   i_input_vec,
  input  logic                             i_input_vec_valid,
  input  logic                             i_acc_en,
  input  logic                             i_acc_clr,
  output logic [DATA_W-1:0]                o_inner_prod,
  output logic                             o_inner_prod_valid,
  output logic                             o_inner_prod_ovf
);

  // Number of adder-tree levels, product width and full inner-product width.
  localparam int LVL = $clog2(N_ELEMS);
  localparam int PW  = 2 * DATA_W;
  localparam int FW  = PW + LVL;

  logic [N_ELEMS-1:0][DATA_W-1:0] coef_q;
  logic [LVL:0]                   vld_q;
  logic [LVL:0]                   en_q;
  logic [LVL:0]                   clr_q;
  logic [FW-1:0]                  p_full;
  logic [DATA_W-1:0]              acc_q;
  logic                           out_vld_q;
  logic                           out_ovf_q;
  logic                           acc_mode;
  logic [DATA_W:0]                sum_d;
  logic                           ovf_d;

  // Coefficient shadow: a beat sampled in the load cycle still multiplies by the old values.
  always_ff @(posedge i_clk) begin
    if (i_sync_rst) begin
      coef_q <= '0;
    end else if (i_coef_load) begin
      coef_q <= i_coef_vec;
    end
  end

  // Valid chain, aligned with the product stage and each tree level; reset flushes beats in flight.
  always_ff @(posedge i_clk) begin
    if (i_sync_rst) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= i_input_vec_valid;
      for (int s = 1; s <= LVL; s++) begin
        vld_q[s] <= vld_q[s-1];
      end
    end
  end

  // Accumulate sideband travels with the data; qualified by the valid chain, so no reset needed.
  always_ff @(posedge i_clk) begin
    en_q[0]  <= i_acc_en;
    clr_q[0] <= i_acc_clr;
    for (int s = 1; s <= LVL; s++) begin
      en_q[s]  <= en_q[s-1];
      clr_q[s] <= clr_q[s-1];
    end
  end

  // Level 0 holds the full-precision products; each further level halves the node count
  // and grows by one bit. An odd leftover node is passed up zero-extended.
  for (genvar l = 0; l <= LVL; l++) begin : g_lvl
    localparam int W   = PW + l;
    localparam int CNT = (N_ELEMS + (1 << l) - 1) >> l;
    logic [W-1:0] node_q [CNT];

    if (l == 0) begin : g_mul
      for (genvar j = 0; j < CNT; j++) begin : g_node
        // Stage 1: register each element product at full width.
        always_ff @(posedge i_clk) begin
          node_q[j] <= PW'(i_input_vec[j]) * PW'(coef_q[j]);
        end
      end
    end else begin : g_add
      localparam int PCNT = (N_ELEMS + (1 << (l - 1)) - 1) >> (l - 1);
      for (genvar j = 0; j < CNT; j++) begin : g_node
        if (2 * j + 1 < PCNT) begin : g_pair
          // Sum a pair of nodes from the level below.
          always_ff @(posedge i_clk) begin
            node_q[j] <= {1'b0, g_lvl[l-1].node_q[2*j]} + {1'b0, g_lvl[l-1].node_q[2*j+1]};
          end
        end else begin : g_pass
          // Odd leftover node: forward with zero padding.
          always_ff @(posedge i_clk) begin
            node_q[j] <= {1'b0, g_lvl[l-1].node_q[2*j]};
          end
        end
      end
    end
  end

  assign p_full = g_lvl[LVL].node_q[0];

  // Output stage next-state: truncate the product, optionally add the accumulator, flag lost bits.
  always_comb begin
    acc_mode = en_q[LVL] & ~clr_q[LVL];
    sum_d    = {1'b0, p_full[DATA_W-1:0]};
    if (acc_mode) begin
      sum_d = {1'b0, acc_q} + {1'b0, p_full[DATA_W-1:0]};
    end
    ovf_d = (|p_full[FW-1:DATA_W]) | (acc_mode & sum_d[DATA_W]);
  end

  // Output/accumulator register: the accumulator is the last emitted result, held on idle cycles.
  always_ff @(posedge i_clk) begin
    if (i_sync_rst) begin
      acc_q     <= '0;
      out_vld_q <= 1'b0;
      out_ovf_q <= 1'b0;
    end else begin
      out_vld_q <= vld_q[LVL];
      out_ovf_q <= vld_q[LVL] & ovf_d;
      if (vld_q[LVL]) begin
        acc_q <= sum_d[DATA_W-1:0];
      end
    end
  end

  assign o_inner_prod       = acc_q;
  assign o_inner_prod_valid = out_vld_q;
  assign o_inner_prod_ovf   = out_ovf_q;

endmodule
